// File: rtl/rv32i_pkg.sv
// rv32i_pkg: shared writeback constants, request bundle type
// and the one-hot to index helper.
package rv32i_pkg;

   localparam int XLEN   = 32;
   localparam int REG_AW = 5;

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] reg_idx;
      logic [XLEN-1:0]   data;
   } wb_req_t;

   function automatic logic [2:0] onehot_to_idx(
      input logic [7:0] oh
   );
      logic [2:0] idx;
      idx = '0;
      for (int i = 0; i < 8; i++) begin
         if (oh[i]) idx = idx | 3'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rv32i_rr_picker.sv
// rv32i_rr_picker: combinational round-robin pick.
// Scans from ptr upwards (mod N); first set request wins.
module rv32i_rr_picker
   import rv32i_pkg::*;
#(
   parameter int N  = 3,
   parameter int PW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [PW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [PW-1:0] gnt_idx
);

   int j;

   // walk offsets high to low so the nearest to ptr wins last
   always_comb begin
      gnt = '0;
      j   = 0;
      for (int k = N - 1; k >= 0; k--) begin
         j = int'(ptr) + k;
         if (j >= N) j = j - N;
         if (req[j]) begin
            gnt    = '0;
            gnt[j] = 1'b1;
         end
      end
   end

   assign gnt_idx = PW'(onehot_to_idx(8'(gnt)));

endmodule

// File: rtl/rv32i_wb_arbiter.sv
// rv32i_wb_arbiter: round-robin writeback port arbiter.
// Option RV32I_WB_X0_DROP_EN: granted x0 writes keep the port quiet.
module rv32i_wb_arbiter #(
   parameter int NUM_REQ = 3,
   parameter int XLEN    = 32,
   parameter int REG_AW  = 5,
   parameter int CNT_W   = 16
) (
   input  logic                      clk,
   input  logic                      reset_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic [NUM_REQ*REG_AW-1:0] req_reg,
   input  logic [NUM_REQ*XLEN-1:0]   req_data,
   input  logic [REG_AW-1:0]         rs1_reg,
   input  logic [REG_AW-1:0]         rs2_reg,
   output logic                      rs1_pending,
   output logic                      rs2_pending,
   output logic                      wb_enable,
   output logic [REG_AW-1:0]         wb_reg,
   output logic [XLEN-1:0]           wb_data,
   output logic [CNT_W-1:0]          contention_cnt
);

   localparam int PW = $clog2(NUM_REQ);

   logic [PW-1:0]      rr_ptr;
   logic [NUM_REQ-1:0] gnt;
   logic [PW-1:0]      gnt_idx;
   logic               fire;
   logic               wr;
   logic [REG_AW-1:0]  sel_reg;
   logic [XLEN-1:0]    sel_data;
   logic               multi;
   int                 nvld;

   rv32i_rr_picker #(
      .N  (NUM_REQ),
      .PW (PW)
   ) u_pick (
      .req     (req_valid),
      .ptr     (rr_ptr),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   assign req_ready = reset_n ? gnt : '0;
   assign fire      = |req_ready;
   assign sel_reg   = req_reg[int'(gnt_idx)*REG_AW +: REG_AW];
   assign sel_data  = req_data[int'(gnt_idx)*XLEN +: XLEN];

`ifdef RV32I_WB_X0_DROP_EN
   assign wr = fire && (sel_reg != '0);
`else
   assign wr = fire;
`endif

   // count valid requesters to detect contention
   always_comb begin
      nvld = 0;
      for (int i = 0; i < NUM_REQ; i++) begin
         nvld = nvld + int'(req_valid[i]);
      end
      multi = (nvld >= 2);
   end

   // hazard lookup against output stage and waiting requests
   always_comb begin
      rs1_pending = 1'b0;
      rs2_pending = 1'b0;
      if (wb_enable && wb_reg == rs1_reg) rs1_pending = 1'b1;
      if (wb_enable && wb_reg == rs2_reg) rs2_pending = 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (req_valid[i] &&
             req_reg[i*REG_AW +: REG_AW] == rs1_reg)
            rs1_pending = 1'b1;
         if (req_valid[i] &&
             req_reg[i*REG_AW +: REG_AW] == rs2_reg)
            rs2_pending = 1'b1;
      end
      if (rs1_reg == '0) rs1_pending = 1'b0;
      if (rs2_reg == '0) rs2_pending = 1'b0;
   end

   // registered write port; index and data hold when idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wb_enable <= 1'b0;
         wb_reg    <= '0;
         wb_data   <= '0;
      end else begin
         wb_enable <= wr;
         if (wr) begin
            wb_reg  <= sel_reg;
            wb_data <= sel_data;
         end
      end
   end

   // pointer moves just past the winner
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rr_ptr <= '0;
      end else if (fire) begin
         if (gnt_idx == PW'(NUM_REQ - 1))
            rr_ptr <= '0;
         else
            rr_ptr <= gnt_idx + 1'b1;
      end
   end

   // saturating contention counter
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         contention_cnt <= '0;
      end else if (multi && contention_cnt != '1) begin
         contention_cnt <= contention_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_rv32i_wb_arbiter.sv
// tb_rv32i_wb_arbiter: directed and random checks of the
// writeback arbiter against a behavioural model.
module tb_rv32i_wb_arbiter;

   localparam int N  = 3;
   localparam int XL = 32;
   localparam int RA = 5;

   bit clk;
   logic            rst_n;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    ready, ready4;
   logic [N*RA-1:0] req_reg;
   logic [N*XL-1:0] req_data;
   logic [RA-1:0]   rs1, rs2;
   logic            p1, p2, p1s, p2s;
   logic            wb_en, wb_en4;
   logic [RA-1:0]   wb_reg, wb_reg4;
   logic [XL-1:0]   wb_data, wb_data4;
   logic [15:0]     cnt;
   logic [3:0]      cnt4;

   int vectors = 0;
   int miscompares = 0;

   // model state
   int          m_ptr;
   bit          m_en;
   logic [4:0]  m_reg;
   logic [31:0] m_data;
   int          m_cnt, m_cnt4;
   int          m_g;
   // staged next state
   int          n_ptr, n_cnt, n_cnt4, n_g;
   bit          n_en;
   logic [4:0]  n_reg;
   logic [31:0] n_data;

   rv32i_wb_arbiter #(
      .NUM_REQ(N), .XLEN(XL), .REG_AW(RA), .CNT_W(16)
   ) u_dut (
      .clk(clk), .reset_n(rst_n),
      .req_valid(req_valid), .req_ready(ready),
      .req_reg(req_reg), .req_data(req_data),
      .rs1_reg(rs1), .rs2_reg(rs2),
      .rs1_pending(p1), .rs2_pending(p2),
      .wb_enable(wb_en), .wb_reg(wb_reg),
      .wb_data(wb_data), .contention_cnt(cnt)
   );

   rv32i_wb_arbiter #(
      .NUM_REQ(N), .XLEN(XL), .REG_AW(RA), .CNT_W(4)
   ) u_sat (
      .clk(clk), .reset_n(rst_n),
      .req_valid(req_valid), .req_ready(ready4),
      .req_reg(req_reg), .req_data(req_data),
      .rs1_reg(rs1), .rs2_reg(rs2),
      .rs1_pending(p1s), .rs2_pending(p2s),
      .wb_enable(wb_en4), .wb_reg(wb_reg4),
      .wb_data(wb_data4), .contention_cnt(cnt4)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm,
                      input logic [63:0] act,
                      input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
      end
   endtask

   function automatic int exp_grant();
      int j;
      for (int k = 0; k < N; k++) begin
         j = (m_ptr + k) % N;
         if (req_valid[j]) return j;
      end
      return -1;
   endfunction

   function automatic bit pend(input logic [4:0] rs);
      if (rs == 0) return 0;
      if (m_en && m_reg == rs) return 1;
      for (int i = 0; i < N; i++)
         if (req_valid[i] && req_reg[i*RA +: RA] == rs)
            return 1;
      return 0;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_en = 0; m_reg = 0; m_data = 0;
      m_cnt = 0; m_cnt4 = 0; m_g = -1;
   endtask

   // negedge: compare everything, then stage next model state
   task automatic at_neg();
      int g, nv;
      logic [N-1:0] er;
      @(negedge clk);
      g  = rst_n ? exp_grant() : -1;
      er = (g >= 0) ? N'(1 << g) : '0;
      chk("ready", 64'(ready), 64'(er));
      chk("ready_sat", 64'(ready4), 64'(er));
      chk("wb_enable", 64'(wb_en), 64'(m_en));
      chk("wb_reg", 64'(wb_reg), 64'(m_reg));
      chk("wb_data", 64'(wb_data), 64'(m_data));
      chk("cnt", 64'(cnt), 64'(m_cnt));
      chk("cnt_sat", 64'(cnt4), 64'(m_cnt4));
      chk("rs1_pending", 64'(p1), 64'(pend(rs1)));
      chk("rs2_pending", 64'(p2), 64'(pend(rs2)));
      n_ptr = m_ptr; n_en = 0; n_reg = m_reg;
      n_data = m_data; n_g = g;
      n_cnt = m_cnt; n_cnt4 = m_cnt4;
      if (g >= 0) begin
         n_ptr = (g + 1) % N;
`ifdef RV32I_WB_X0_DROP_EN
         if (req_reg[g*RA +: RA] != 0) begin
`else
         begin
`endif
            n_en   = 1;
            n_reg  = req_reg[g*RA +: RA];
            n_data = req_data[g*XL +: XL];
         end
      end
      nv = $countones(req_valid);
      if (rst_n && nv >= 2) begin
         if (n_cnt < 65535) n_cnt++;
         if (n_cnt4 < 15) n_cnt4++;
      end
   endtask

   task automatic adv();
      @(posedge clk);
      if (rst_n) begin
         m_ptr = n_ptr; m_en = n_en; m_reg = n_reg;
         m_data = n_data; m_cnt = n_cnt; m_cnt4 = n_cnt4;
         m_g = n_g;
      end else begin
         model_reset();
      end
      #1;
   endtask

   task automatic do_reset();
      rst_n = 0;
      model_reset();
      at_neg();
      adv();
      rst_n = 1;
   endtask

   task automatic set_req(input int i, input logic [4:0] r,
                          input logic [31:0] d);
      req_reg[i*RA +: RA]  = r;
      req_data[i*XL +: XL] = d;
   endtask

   initial begin
      rst_n = 0; req_valid = '1;
      req_reg = '0; req_data = '0; rs1 = 0; rs2 = 0;
      model_reset();
      set_req(0, 5'd1, 32'h11);
      set_req(1, 5'd2, 32'h22);
      set_req(2, 5'd3, 32'h33);
      #1;
      // reset held with all valid
      at_neg();
      chk("rst_ready", 64'(ready), 64'h0);
      chk("rst_wb_enable", 64'(wb_en), 64'h0);
      chk("rst_cnt", 64'(cnt), 64'h0);
      adv();
      rst_n = 1;
      at_neg();
      chk("first_grant", 64'(ready), 64'h1);
      adv();

      // single requester
      do_reset();
      req_valid = 3'b010;
      set_req(1, 5'd5, 32'hDEADBEEF);
      at_neg();
      chk("single_ready", 64'(ready), 64'h2);
      adv();
      req_valid = '0;
      at_neg();
      chk("single_en", 64'(wb_en), 64'h1);
      chk("single_reg", 64'(wb_reg), 64'h5);
      chk("single_data", 64'(wb_data), 64'hDEADBEEF);
      adv();
      at_neg();
      chk("single_idle", 64'(wb_en), 64'h0);
      adv();

      // round robin, all valid
      do_reset();
      req_valid = 3'b111;
      for (int k = 0; k < 6; k++) begin
         at_neg();
         chk("rr_order", 64'(ready), 64'(1 << (k % 3)));
         adv();
      end
      req_valid = '0;
      at_neg();
      chk("rr_cnt", 64'(cnt), 64'd6);
      adv();

      // hazard flags
      do_reset();
      req_valid = 3'b100;
      set_req(2, 5'd7, 32'hCAFE0007);
      rs1 = 5'd7; rs2 = 5'd0;
      at_neg();
      chk("haz_req", 64'(p1), 64'h1);
      chk("haz_ready", 64'(ready), 64'h4);
      adv();
      req_valid = '0;
      at_neg();
      chk("haz_out", 64'(p1), 64'h1);
      adv();
      at_neg();
      chk("haz_clear", 64'(p1), 64'h0);
      adv();
      req_valid = 3'b001;
      set_req(0, 5'd0, 32'h0);
      rs1 = 5'd0;
      at_neg();
      chk("haz_x0", 64'(p1), 64'h0);
      adv();
      req_valid = '0;

      // counter saturation
      do_reset();
      req_valid = 3'b011;
      for (int k = 0; k < 20; k++) begin
         at_neg();
         adv();
      end
      req_valid = '0;
      at_neg();
      chk("sat_cnt4", 64'(cnt4), 64'd15);
      chk("sat_cnt16", 64'(cnt), 64'd20);
      adv();

      // write to x0
      do_reset();
      req_valid = 3'b001;
      set_req(0, 5'd0, 32'h12345678);
      at_neg();
      chk("x0_ready", 64'(ready), 64'h1);
      adv();
      req_valid = 3'b011;
      set_req(1, 5'd9, 32'h99);
      at_neg();
`ifdef RV32I_WB_X0_DROP_EN
      chk("x0_en", 64'(wb_en), 64'h0);
      chk("x0_reg", 64'(wb_reg), 64'h0);
      chk("x0_data", 64'(wb_data), 64'h0);
`else
      chk("x0_en", 64'(wb_en), 64'h1);
      chk("x0_reg", 64'(wb_reg), 64'h0);
      chk("x0_data", 64'(wb_data), 64'h12345678);
`endif
      chk("x0_ptr", 64'(ready), 64'h2);
      adv();

      // random traffic, requesters hold until handshake
      do_reset();
      req_valid = '0;
      for (int c = 0; c < 3000; c++) begin
         for (int i = 0; i < N; i++) begin
            if (!req_valid[i] || m_g == i) begin
               req_valid[i] = ($urandom_range(0, 99) < 60);
               set_req(i, 5'($urandom_range(0, 7)), $urandom);
            end
         end
         rs1 = 5'($urandom_range(0, 7));
         rs2 = 5'($urandom_range(0, 7));
         at_neg();
         adv();
      end
      req_valid = '0;
      at_neg();
      adv();

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
